// File: rtl/fifo_pkg.sv
// Constants and the word type shared by the synchronous FIFO and its read-side packer.
package fifo_pkg;
    localparam int FIFO_WIDTH = 16;
    localparam int FIFO_DEPTH = 8;
    typedef logic [FIFO_WIDTH-1:0] word_t;
endpackage

// File: rtl/pack_out_stage.sv
// Output register of the packer: holds one beat until the downstream accepts it.
module pack_out_stage #(
    parameter int DW = 32,
    parameter int KW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ld,
    input  logic [DW-1:0] ld_data,
    input  logic [KW-1:0] ld_keep,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic [KW-1:0] m_keep,
    output logic          m_valid,
    output logic          free
);
    logic [DW-1:0] data_q;
    logic [KW-1:0] keep_q;
    logic          valid_q;

    // ld is only raised while free, so a held beat is never overwritten.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            keep_q  <= '0;
            valid_q <= 1'b0;
        end else if (ld) begin
            data_q  <= ld_data;
            keep_q  <= ld_keep;
            valid_q <= 1'b1;
        end else if (m_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign free    = !valid_q || m_ready;
    assign m_data  = data_q;
    assign m_keep  = keep_q;
    assign m_valid = valid_q;
endmodule

// File: rtl/fifo_rd_packer.sv
// Drains FIFO words (one-cycle read latency) and packs PACK of them into one
// valid/ready beat; flush emits a partial beat, underflow is latched sticky.
module fifo_rd_packer
    import fifo_pkg::*;
#(
    parameter int IN_WIDTH = FIFO_WIDTH,
    parameter int PACK     = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     fifo_empty,
    input  logic                     fifo_underflow,
    input  logic [IN_WIDTH-1:0]      fifo_data_out,
    output logic                     fifo_rd_en,
    input  logic                     flush,
    output logic [IN_WIDTH*PACK-1:0] m_data,
    output logic [PACK-1:0]          m_keep,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic                     underflow_err
);
    localparam int CW = $clog2(PACK + 1);

    word_t [PACK-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             pending_q;
    logic             flush_req_q, flush_req_d;
    logic             err_q;
    logic             out_free, xfer, flush_ready, flush_done;
    logic [PACK-1:0]  xfer_keep;

    // A read is issued only if the word it returns is guaranteed a lane.
    assign fifo_rd_en = !rst && !fifo_empty && !flush_req_q &&
                        ((int'(cnt_q) + int'(pending_q)) < PACK);

    assign flush_ready = flush_req_q && !pending_q;
    assign xfer        = out_free && ((cnt_q == CW'(PACK)) || (flush_ready && cnt_q != '0));
    assign flush_done  = flush_ready && ((cnt_q == '0) || xfer);
    assign flush_req_d = flush_req_q ? !flush_done : flush;

    // A full accumulator implies no read in flight, so xfer and capture never coincide.
    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (xfer) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (pending_q) begin
            for (int i = 0; i < PACK; i++) begin
                if (cnt_q == CW'(i)) acc_d[i] = fifo_data_out;
            end
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_comb begin
        xfer_keep = '0;
        for (int i = 0; i < PACK; i++) xfer_keep[i] = (CW'(i) < cnt_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            pending_q   <= 1'b0;
            flush_req_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            pending_q   <= fifo_rd_en;
            flush_req_q <= flush_req_d;
            err_q       <= err_q | fifo_underflow;
        end
    end

    assign underflow_err = err_q;

    pack_out_stage #(
        .DW (IN_WIDTH * PACK),
        .KW (PACK)
    ) u_out (
        .clk     (clk),
        .rst     (rst),
        .ld      (xfer),
        .ld_data (acc_q),
        .ld_keep (xfer_keep),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_keep  (m_keep),
        .m_valid (m_valid),
        .free    (out_free)
    );
endmodule

// File: tb/tb_fifo_rd_packer.sv
// Bench for fifo_rd_packer: behavioural FIFO, word-level packing model and a
// scoreboard monitor that checks every accepted beat and every held beat.
module tb_fifo_rd_packer;
    import fifo_pkg::*;

    localparam int PACK = 2;
    localparam int W    = FIFO_WIDTH;
    localparam int OW   = W * PACK;

    typedef struct packed {
        logic [OW-1:0]   d;
        logic [PACK-1:0] k;
    } beat_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            fifo_empty = 1'b1;
    logic            fifo_underflow = 1'b0;
    logic [W-1:0]    fifo_data_out = '0;
    logic            fifo_rd_en;
    logic            flush = 1'b0;
    logic [OW-1:0]   m_data;
    logic [PACK-1:0] m_keep;
    logic            m_valid;
    logic            m_ready = 1'b0;
    logic            underflow_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rd_cnt = 0;
    int beat_cnt = 0;
    int rdy_mode = 1;
    int acc_cyc[$];

    logic         wr_en = 1'b0;
    logic [W-1:0] wr_data = '0;
    logic [W-1:0] fq[$];
    logic [W-1:0] ref_acc[$];
    beat_t        exp_q[$];

    always #5 clk = ~clk;

    fifo_rd_packer #(.IN_WIDTH(W), .PACK(PACK)) dut (
        .clk            (clk),
        .rst            (rst),
        .fifo_empty     (fifo_empty),
        .fifo_underflow (fifo_underflow),
        .fifo_data_out  (fifo_data_out),
        .fifo_rd_en     (fifo_rd_en),
        .flush          (flush),
        .m_data         (m_data),
        .m_keep         (m_keep),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .underflow_err  (underflow_err)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Behavioural synchronous FIFO: data_out valid the cycle after rd_en.
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            fq.delete();
            fifo_empty <= 1'b1;
        end else begin
            if (fifo_rd_en) begin
                rd_cnt++;
                checks++;
                if (fq.size() == 0) begin
                    errors++;
                    $display("FAIL rd_on_empty actual=read expected=no_read");
                end else begin
                    fifo_data_out <= fq.pop_front();
                end
            end
            if (wr_en) fq.push_back(wr_data);
            fifo_empty <= (fq.size() == 0);
        end
    end

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       m_ready = 1'b0;
            1:       m_ready = 1'b1;
            default: m_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: a beat seen valid with ready at the negedge is accepted at the next edge.
    logic [OW-1:0]   hold_d;
    logic [PACK-1:0] hold_k;
    bit              holding = 1'b0;
    beat_t           e;
    always @(negedge clk) begin
        if (rst) begin
            holding = 1'b0;
        end else begin
            if (holding) begin
                checks++;
                if (m_valid !== 1'b1 || m_data !== hold_d || m_keep !== hold_k) begin
                    errors++;
                    $display("FAIL hold actual=%b/%h/%b expected=1/%h/%b",
                             m_valid, m_data, m_keep, hold_d, hold_k);
                end
            end
            holding = 1'b0;
            if (m_valid === 1'b1 && m_ready === 1'b1) begin
                checks++;
                beat_cnt++;
                acc_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL beat_unexpected actual=%h/%b expected=none", m_data, m_keep);
                end else begin
                    e = exp_q.pop_front();
                    if (m_data !== e.d || m_keep !== e.k) begin
                        errors++;
                        $display("FAIL beat actual=%h/%b expected=%h/%b", m_data, m_keep, e.d, e.k);
                    end
                end
            end else if (m_valid === 1'b1) begin
                holding = 1'b1;
                hold_d  = m_data;
                hold_k  = m_keep;
            end
        end
    end

    // Model: words are grouped PACK at a time in FIFO order; a flush closes a partial group.
    task automatic close_group();
        beat_t b;
        b.d = '0;
        b.k = '0;
        for (int i = 0; i < ref_acc.size(); i++) begin
            b.d[i*W +: W] = ref_acc[i];
            b.k[i]        = 1'b1;
        end
        exp_q.push_back(b);
        ref_acc.delete();
    endtask

    task automatic push_word(input logic [W-1:0] w);
        wr_en   = 1'b1;
        wr_data = w;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        ref_acc.push_back(w);
        if (ref_acc.size() == PACK) close_group();
    endtask

    task automatic wait_drain(input string nm);
        int n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(nm, 64'(exp_q.size()), 64'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic do_flush();
        int n = 0;
        while ((fq.size() != 0 || fifo_empty !== 1'b1) && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 1000) begin
            checks++;
            errors++;
            $display("FAIL flush_quiesce actual=timeout expected=fifo_empty");
        end
        repeat (2) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        if (ref_acc.size() > 0) close_group();
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        ref_acc.delete();
        @(posedge clk);
        @(negedge clk);
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_m_data", 64'(m_data), 64'd0);
        chk("rst_m_keep", 64'(m_keep), 64'd0);
        chk("rst_rd_en", 64'(fifo_rd_en), 64'd0);
        chk("rst_underflow_err", 64'(underflow_err), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int beats_before;
        repeat (2) @(posedge clk);
        apply_reset();

        // Two words make one full beat.
        rdy_mode = 1;
        rd_cnt   = 0;
        push_word(16'h1111);
        push_word(16'h2222);
        wait_drain("t1_drain");
        chk("t1_rd_pulses", 64'(rd_cnt), 64'd2);
        chk("t1_fifo_empty", 64'(fifo_empty), 64'd1);

        // Eight words back to back: four beats, steady spacing of PACK+2 cycles.
        acc_cyc.delete();
        for (int i = 1; i <= 8; i++) push_word(W'(i));
        wait_drain("t2_drain");
        chk("t2_beats", 64'(acc_cyc.size()), 64'd4);
        if (acc_cyc.size() == 4) begin
            chk("t2_period_a", 64'(acc_cyc[2] - acc_cyc[1]), 64'(PACK + 2));
            chk("t2_period_b", 64'(acc_cyc[3] - acc_cyc[2]), 64'(PACK + 2));
        end

        // Downstream stall: one beat held, one full accumulator, reads stop at four.
        rdy_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        rd_cnt = 0;
        for (int i = 1; i <= 6; i++) push_word(W'(i));
        repeat (20) @(posedge clk);
        #1;
        chk("t3_valid", 64'(m_valid), 64'd1);
        if (exp_q.size() > 0) chk("t3_held_data", 64'(m_data), 64'(exp_q[0].d));
        chk("t3_reads", 64'(rd_cnt), 64'd4);
        rdy_mode = 1;
        wait_drain("t3_drain");

        // Flush with one word gives a partial beat; a second flush gives nothing.
        push_word(16'h00AB);
        do_flush();
        wait_drain("t4_drain");
        beats_before = beat_cnt;
        do_flush();
        repeat (10) @(posedge clk);
        #1;
        chk("t4_no_beat", 64'(beat_cnt), 64'(beats_before));

        // Reset the cycle after a read: the returning word must be dropped.
        push_word(16'hDEAD);
        n = 0;
        while (fifo_rd_en !== 1'b1 && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("t5_rd_seen", 64'(fifo_rd_en), 64'd1);
        @(posedge clk);
        #1;
        apply_reset();
        push_word(16'h0B01);
        push_word(16'h0B02);
        wait_drain("t5_drain");

        // Sticky underflow error.
        chk("t6_err_before", 64'(underflow_err), 64'd0);
        fifo_underflow = 1'b1;
        @(posedge clk);
        #1;
        fifo_underflow = 1'b0;
        chk("t6_err_set", 64'(underflow_err), 64'd1);
        repeat (5) @(posedge clk);
        #1;
        chk("t6_err_sticky", 64'(underflow_err), 64'd1);
        apply_reset();

        // Randomized bursts, random backpressure and occasional flushes.
        rdy_mode = 2;
        for (int it = 0; it < 30; it++) begin
            int len = int'($urandom_range(1, 6));
            for (int j = 0; j < len; j++) push_word(W'($urandom));
            n = 0;
            while (fq.size() != 0 && n < 1000) begin
                @(posedge clk);
                #1;
                n++;
            end
            if ($urandom_range(0, 9) < 3) do_flush();
        end
        do_flush();
        rdy_mode = 1;
        wait_drain("t7_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
